// File: rtl/cpu_run_controller.sv
// cpu_run_controller: turns divided-clock rising edges into gated CPU clock-enable pulses with run/halt/step control
module cpu_run_controller #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 32,
  parameter logic        START_RUN       = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             div_clk,
  input  logic             btn_run,
  input  logic             btn_halt,
  input  logic             btn_step,
  output logic             cpu_ce,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] cycle_count
);
  typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, STEP_WAIT = 2'b10} state_t;
  state_t     state;
  logic       s1, s2, s3;
  logic       tick;
  logic [2:0] raw;
  logic [2:0] ev;
  logic       run_ev, halt_ev, step_ev;
  assign raw     = {btn_step, btn_halt, btn_run};
  assign run_ev  = ev[0];
  assign halt_ev = ev[1];
  assign step_ev = ev[2];
  assign tick    = s2 & ~s3;
  assign mode    = state;
  // two-flop synchroniser for div_clk plus one delay flop for rising-edge detection
  always_ff @(posedge clk_in)
    if (!rst_n) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {div_clk, s1, s2};
  for (genvar b = 0; b < 3; b++) begin : g_db
    logic [15:0] cnt;
    logic        lvl;
    logic        pe;
    assign ev[b] = pe;
    // accept a new level only after it has differed from the current one for DEBOUNCE_CYCLES edges in a row
    always_ff @(posedge clk_in)
      if (!rst_n) begin
        cnt <= '0;
        lvl <= 1'b0;
        pe  <= 1'b0;
      end else if (raw[b] == lvl) begin
        cnt <= '0;
        pe  <= 1'b0;
      end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
        cnt <= '0;
        lvl <= raw[b];
        pe  <= raw[b];
      end else begin
        cnt <= cnt + 16'd1;
        pe  <= 1'b0;
      end
  end
  // run/halt/step state machine with the gated enable and retired-enable counter
  always_ff @(posedge clk_in)
    if (!rst_n) begin
      state       <= START_RUN ? RUN : HALT;
      cpu_ce      <= 1'b0;
      cycle_count <= '0;
    end else begin
      cpu_ce      <= tick & ~halt_ev & (state == RUN | state == STEP_WAIT) & ~(state == STEP_WAIT & run_ev);
      cycle_count <= cycle_count + CNT_W'(cpu_ce);
      unique case (state)
        HALT:      state <= halt_ev ? HALT : run_ev ? RUN : step_ev ? STEP_WAIT : HALT;
        RUN:       state <= halt_ev ? HALT : RUN;
        STEP_WAIT: state <= halt_ev ? HALT : run_ev ? RUN : tick ? HALT : STEP_WAIT;
        default:   state <= HALT;
      endcase
    end
endmodule
